// File: rtl/conv_post_quant.sv
// Post-convolution quantizer: per-lane bias add, optional ReLU, unsigned scale,
// round-half-up arithmetic shift and saturation, over a 3-stage elastic pipeline.
module conv_post_quant #(
   parameter  int unsigned N_LANE = 40,
   parameter  int unsigned ACC_W  = 32,
   parameter  int unsigned BIAS_W = 16,
   parameter  int unsigned OUT_W  = 8,
   parameter  int unsigned N_CH   = 32,
   localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cfg_we,
   input  logic [CH_W+1:0]         cfg_addr,
   input  logic [15:0]             cfg_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [CH_W-1:0]         in_ch,
   input  logic [N_LANE*ACC_W-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [N_LANE*OUT_W-1:0] out_data,
   output logic [15:0]             sat_cnt
);
   localparam int unsigned SW = ACC_W + 1;
   localparam int unsigned PW = ACC_W + 18;
   // Extra headroom so the rounding constant (up to 2^30) never overflows.
   localparam int unsigned RW = (PW + 1 > 33) ? PW + 1 : 33;

   localparam logic [CH_W+1:0] A_SCALE = (CH_W+2)'(N_CH);
   localparam logic [CH_W+1:0] A_SHIFT = (CH_W+2)'(N_CH + 1);
   localparam logic [CH_W+1:0] A_MODE  = (CH_W+2)'(N_CH + 2);
   localparam logic [CH_W+1:0] A_CLR   = (CH_W+2)'(N_CH + 3);

   localparam logic signed [RW-1:0] OUT_HI = RW'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [RW-1:0] OUT_LO = ~OUT_HI;

   // Configuration registers
   logic signed [BIAS_W-1:0] bias_q [N_CH];
   logic [15:0]              scale_q;
   logic [4:0]               shift_q;
   logic [1:0]               mode_q;

   // Pipeline state
   logic                      s1_v_q;
   logic [N_LANE-1:0][SW-1:0] s1_sum_d, s1_sum_q;
   logic [15:0]               s1_scale_q;
   logic [4:0]                s1_shift_q;
   logic [1:0]                s1_mode_q;

   logic                      s2_v_q;
   logic [N_LANE-1:0][PW-1:0] s2_prod_d, s2_prod_q;
   logic [4:0]                s2_shift_q;
   logic                      s2_signed_q;

   logic                      out_valid_q;
   logic [N_LANE*OUT_W-1:0]   s3_data_d, out_data_q;
   logic                      s3_sat_d, s3_sat_q;
   logic [15:0]               sat_cnt_q;

   logic                      adv_c;
   logic                      clr_c;
   logic signed [BIAS_W-1:0]  bias_sel_c;
   logic signed [SW-1:0]      sum_v;
   logic signed [RW-1:0]      rnd_c, lo_c, r_v, c_v;

   assign adv_c     = out_ready | ~out_valid_q;
   assign clr_c     = cfg_we && (cfg_addr == A_CLR);
   assign in_ready  = adv_c;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign sat_cnt   = sat_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(N_CH); i++) bias_q[i] <= '0;
         scale_q <= 16'd1;
         shift_q <= 5'd0;
         mode_q  <= 2'b01;
      end else if (cfg_we) begin
         if (32'(cfg_addr) < N_CH)    bias_q[cfg_addr[CH_W-1:0]] <= cfg_data[BIAS_W-1:0];
         else if (cfg_addr == A_SCALE) scale_q <= cfg_data;
         else if (cfg_addr == A_SHIFT) shift_q <= cfg_data[4:0];
         else if (cfg_addr == A_MODE)  mode_q  <= cfg_data[1:0];
      end
   end

   // S1: bias add at ACC_W+1 bits
   always_comb begin
      s1_sum_d   = '0;
      bias_sel_c = (32'(in_ch) < N_CH) ? bias_q[in_ch] : '0;
      for (int i = 0; i < int'(N_LANE); i++) begin
         s1_sum_d[i] = SW'($signed(in_data[i*ACC_W +: ACC_W])) + SW'(bias_sel_c);
      end
   end

   // S2: optional ReLU, then signed multiply by zero-extended scale
   always_comb begin
      s2_prod_d = '0;
      sum_v     = '0;
      for (int i = 0; i < int'(N_LANE); i++) begin
         sum_v = $signed(s1_sum_q[i]);
         if (s1_mode_q[0] && (sum_v < 0)) sum_v = '0;
         s2_prod_d[i] = PW'(sum_v) * PW'($signed({1'b0, s1_scale_q}));
      end
   end

   // S3: round-half-up shift, clamp, flag any clamped lane
   always_comb begin
      s3_data_d = '0;
      s3_sat_d  = 1'b0;
      r_v       = '0;
      c_v       = '0;
      rnd_c     = (s2_shift_q != 5'd0) ? (RW'(1) << (s2_shift_q - 5'd1)) : '0;
      lo_c      = s2_signed_q ? OUT_LO : '0;
      for (int i = 0; i < int'(N_LANE); i++) begin
         r_v = (RW'($signed(s2_prod_q[i])) + rnd_c) >>> s2_shift_q;
         if (r_v > OUT_HI) begin
            c_v      = OUT_HI;
            s3_sat_d = 1'b1;
         end else if (r_v < lo_c) begin
            c_v      = lo_c;
            s3_sat_d = 1'b1;
         end else begin
            c_v = r_v;
         end
         s3_data_d[i*OUT_W +: OUT_W] = c_v[OUT_W-1:0];
      end
   end

   // All stages move together; a stall freezes data and valids alike.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q      <= 1'b0;
         s1_sum_q    <= '0;
         s1_scale_q  <= '0;
         s1_shift_q  <= '0;
         s1_mode_q   <= '0;
         s2_v_q      <= 1'b0;
         s2_prod_q   <= '0;
         s2_shift_q  <= '0;
         s2_signed_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         s3_sat_q    <= 1'b0;
      end else if (adv_c) begin
         s1_v_q      <= in_valid;
         s1_sum_q    <= s1_sum_d;
         s1_scale_q  <= scale_q;
         s1_shift_q  <= shift_q;
         s1_mode_q   <= mode_q;
         s2_v_q      <= s1_v_q;
         s2_prod_q   <= s2_prod_d;
         s2_shift_q  <= s1_shift_q;
         s2_signed_q <= s1_mode_q[1];
         out_valid_q <= s2_v_q;
         out_data_q  <= s3_data_d;
         s3_sat_q    <= s3_sat_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_cnt_q <= '0;
      end else if (clr_c) begin
         sat_cnt_q <= '0;
      end else if (out_valid_q && out_ready && s3_sat_q && (sat_cnt_q != 16'hFFFF)) begin
         sat_cnt_q <= sat_cnt_q + 16'd1;
      end
   end

endmodule

// File: doc/conv_post_quant.md
CONV_POST_QUANT -- requirements
Module: conv_post_quant

Interface
REQ-001 SHALL have parameter N_LANE, default 40, parallel convolution lanes per beat.
REQ-002 SHALL have parameter ACC_W, default 32, signed accumulator width per lane.
REQ-003 SHALL have parameter BIAS_W, default 16, signed bias width.
REQ-004 SHALL have parameter OUT_W, default 8, output width per lane.
REQ-005 SHALL have parameter N_CH, default 32, bias table depth; CH_W = clog2(N_CH).
REQ-006 SHALL have ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  CH_W+2  config address.
- cfg_data  in  16  config write data.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid and in_ready are both high.
- in_ch  in  CH_W  bias index for the beat.
- in_data  in  N_LANE*ACC_W  lane i at bits [(i+1)*ACC_W-1 -: ACC_W].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  N_LANE*OUT_W  lane i at bits [(i+1)*OUT_W-1 -: OUT_W].
- sat_cnt  out  16  saturated-beat counter.

Function
REQ-007 Config map SHALL be: addr<N_CH bias[addr]=cfg_data[BIAS_W-1:0]; N_CH scale=cfg_data (unsigned); N_CH+1 shift=cfg_data[4:0]; N_CH+2 mode: bit0 relu_en, bit1 signed_out; N_CH+3 clears sat_cnt; other addresses ignored.
REQ-008 Pipeline SHALL have 3 stages (S1 bias add, S2 ReLU+scale, S3 round/shift/saturate), one valid bit per stage.
REQ-009 Advance SHALL be adv = out_ready OR NOT out_valid; in_ready = adv; all stages shift together only when adv=1, and otherwise hold data and valid.
REQ-010 Latency SHALL be 3 cycles from accepted input to out_valid with no backpressure; throughput SHALL be 1 beat/cycle.
REQ-011 bias[in_ch], scale, shift and mode SHALL be sampled into S1 with the beat and travel with it; config writes SHALL affect only beats accepted after the write cycle.
REQ-012 S1 SHALL compute sum = in_data lane (sign-extended to ACC_W+1) + bias (sign-extended).
REQ-013 S2 SHALL clamp sum<0 to 0 when relu_en=1, then form prod = sum * {0,scale}, signed, ACC_W+18 bits, with no overflow possible.
REQ-014 S3 SHALL compute r = (prod + (shift>0 ? 2^(shift-1) : 0)) >>> shift, arithmetic shift with round-half-up.
REQ-015 Saturation SHALL be: signed_out=1 clamps r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; signed_out=0 clamps to [0, 2^(OUT_W-1)-1]; out lane = low OUT_W bits of the clamped value.
REQ-016 sat_cnt SHALL increment by 1 per output handshake (out_valid AND out_ready) in which any lane clamped, and stick at 16'hFFFF.
REQ-017 A clear write to N_CH+3 in the same cycle as an increment SHALL give sat_cnt=0, with the clear taking priority.
REQ-018 An in_ch value >= N_CH SHALL use bias 0.
REQ-019 Backpressure SHALL drop and duplicate no beat; out_data SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-020 On rst_n low, all stage valids, out_valid, out_data, sat_cnt and the bias table SHALL reset to 0; scale SHALL reset to 1, shift to 0, and mode to 2'b01 (ReLU on, unsigned out).
REQ-021 Reset mid-operation SHALL discard all in-flight beats; in_ready SHALL be 1 on the first cycle after release.

Verification
REQ-022 Reset defaults, bias[0]=0, lane=100, out_ready=1 -> out lane=100 (0x64) 3 cycles later; sat_cnt=0.
REQ-023 bias[3]=-50, scale=3, shift=2, in_ch=3, lanes {10,200,60} -> ReLU gives {0,150,10}, times 3 = {0,450,30}, rounded >>2 = {0,113→0x7F sat,8}; sat_cnt=1.
REQ-024 mode=2'b10 (no ReLU, signed), scale=1, shift=0, lane=-300 -> 0x80; lane=-5 -> 0xFB.
REQ-025 Stream 10 beats with out_ready toggling 1,0,0,1... -> exactly 10 handshakes, in order, data held during stalls, in_ready low only while out_valid=1 and out_ready=0.
REQ-026 Write scale=2 the cycle after beat A is accepted, then beat B follows -> A uses old scale, B uses 2; clear sat_cnt coincident with a saturating handshake -> sat_cnt=0.
REQ-027 Assert rst_n low with 3 beats in flight -> out_valid=0 immediately and no stale beat emitted after release.
